tff_count_sequencer: RTL and testbench

//  Controller for an external bank of WIDTH toggle flip-flops wired as a synchronous counter.
//  - On a start command it clears the bank, then drives per-bit toggle enables until q_in equals a latched target.
//  - Supports up and down counting, pause and abort.
//  - Reports completion with a one-cycle done pulse.
//  - Bit i of t_en drives the t input of flop i; tff_clr drives the bank's synchronous active-high clear.

---
 rtl/tff_count_sequencer.sv | 94 +++++++++
 tb/tb_tff_count_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tff_count_sequencer.sv
// rtl/tff_count_sequencer.sv - clear-then-count controller for an external TFF counter bank
// Registered IDLE/CLEAR/RUN/DONE FSM; all outputs are decoded from state, dir_r, q_in and pause.
module tff_count_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] target,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] t_en,
  output logic             tff_clr,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] target_r;
  logic             dir_r;
  logic [WIDTH-1:0] up_en, dn_en;
  logic             all_ones, all_zeros;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      target_r <= '0;
      dir_r    <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        target_r <= target;
        dir_r    <= dir;
      end
    end
  end

  // A bit toggles when every lower bit is 1 (counting up) or 0 (counting down).
  always_comb begin
    up_en     = '0;
    dn_en     = '0;
    all_ones  = 1'b1;
    all_zeros = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_en[i]  = all_ones;
      dn_en[i]  = all_zeros;
      all_ones  = all_ones & q_in[i];
      all_zeros = all_zeros & ~q_in[i];
    end
  end

  always_comb begin
    next_state = state;
    t_en       = '0;
    tff_clr    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = CLEAR;
      end
      CLEAR: begin
        tff_clr    = 1'b1;
        busy       = 1'b1;
        next_state = abort ? IDLE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          next_state = IDLE;
        end else if (q_in == target_r) begin
          next_state = DONE;
        end else if (!pause) begin
          t_en = dir_r ? dn_en : up_en;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tff_count_sequencer.sv
// tb/tb_tff_count_sequencer.sv - bench for tff_count_sequencer driving a 4-bit TFF bank model
module tb_tff_count_sequencer;

  logic       clk, reset, start, dir, pause, abort, load;
  logic [3:0] target, load_val, bank, t_en;
  logic       tff_clr, busy, done;
  int         checks, errors;

  tff_count_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .target(target),
    .pause(pause), .abort(abort), .q_in(bank), .t_en(t_en),
    .tff_clr(tff_clr), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Four T flops with synchronous clear; load is a bench-only preload path.
  always_ff @(posedge clk) begin
    if (load) bank <= load_val;
    else if (tff_clr) bank <= 4'd0;
    else bank <= bank ^ t_en;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_run(input logic d, input logic [3:0] tgt);
    int runlen;
    logic [3:0] q_exp, nq, te_exp;
    runlen = (tgt == 0) ? 1 : (d ? 16 - int'(tgt) + 1 : int'(tgt) + 1);
    start = 1; dir = d; target = tgt;
    step();
    start = 0; dir = 1'($urandom); target = 4'($urandom);
    checks++; if (tff_clr !== 1'b1) begin errors++; $display("FAIL clear_tff_clr got %0b exp 1", tff_clr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy got %0b exp 1", busy); end
    checks++; if (t_en !== 4'd0) begin errors++; $display("FAIL clear_t_en got %0h exp 0", t_en); end
    step();
    for (int k = 0; k < runlen; k++) begin
      q_exp  = d ? 4'(16 - k) : 4'(k);
      nq     = d ? q_exp - 4'd1 : q_exp + 4'd1;
      te_exp = (k == runlen - 1) ? 4'd0 : (nq ^ q_exp);
      checks++; if (bank !== q_exp) begin errors++; $display("FAIL run_q k=%0d got %0h exp %0h", k, bank, q_exp); end
      checks++; if (t_en !== te_exp) begin errors++; $display("FAIL run_t_en k=%0d got %0h exp %0h", k, t_en, te_exp); end
      checks++; if ({busy, done, tff_clr} !== 3'b100) begin errors++; $display("FAIL run_flags k=%0d got %0b exp 100", k, {busy, done, tff_clr}); end
      start = 1'($urandom);
      step();
    end
    start = 0;
    checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL done_pulse got %0b exp 10", {done, busy}); end
    checks++; if (t_en !== 4'd0) begin errors++; $display("FAIL done_t_en got %0h exp 0", t_en); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %0b exp 0", done); end
    checks++; if (bank !== tgt) begin errors++; $display("FAIL final_q got %0h exp %0h", bank, tgt); end
  endtask

  task automatic advance_to(input logic [3:0] v, input string name);
    int n;
    n = 0;
    while (bank !== v && n < 20) begin step(); n++; end
    checks++; if (bank !== v) begin errors++; $display("FAIL %s_reach got %0h exp %0h", name, bank, v); end
  endtask

  task automatic test_reset();
    reset = 0; start = 1; dir = 0; target = 4'd3; pause = 0; abort = 0; load = 0; load_val = 0;
    #1;
    checks++; if ({t_en, tff_clr, busy, done} !== 7'd0) begin errors++; $display("FAIL reset_outputs got %0h exp 0", {t_en, tff_clr, busy, done}); end
    step(); step();
    start = 0; reset = 1;
    step(); step();
    checks++; if ({busy, done, tff_clr} !== 3'b000) begin errors++; $display("FAIL reset_idle got %0b exp 000", {busy, done, tff_clr}); end
  endtask

  task automatic test_count_up();
    load = 1; load_val = 4'd9; step(); load = 0;
    checks++; if (bank !== 4'd9) begin errors++; $display("FAIL preload got %0h exp 9", bank); end
    do_run(1'b0, 4'd5);
  endtask

  task automatic test_count_down();
    do_run(1'b1, 4'd13);
    step(); step();
    checks++; if (bank !== 4'd13) begin errors++; $display("FAIL down_hold got %0h exp d", bank); end
  endtask

  task automatic test_target_zero();
    do_run(1'b0, 4'd0);
    do_run(1'b1, 4'd0);
  endtask

  task automatic test_abort();
    int dcnt;
    start = 1; dir = 0; target = 4'd9; step(); start = 0;
    step();
    advance_to(4'd3, "abort");
    abort = 1; #1;
    checks++; if (t_en !== 4'd0) begin errors++; $display("FAIL abort_t_en got %0h exp 0", t_en); end
    step(); abort = 0;
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got %0b exp 0", busy); end
      if (done) dcnt++;
      step();
    end
    checks++; if (dcnt != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", dcnt); end
    checks++; if (bank !== 4'd3) begin errors++; $display("FAIL abort_frozen got %0h exp 3", bank); end
    start = 1; target = 4'd5; step(); start = 0;
    abort = 1; step(); abort = 0;
    checks++; if ({busy, bank} !== 5'd0) begin errors++; $display("FAIL abort_in_clear got %0h exp 0", {busy, bank}); end
  endtask

  task automatic test_pause();
    int dcnt;
    logic [3:0] qdone;
    start = 1; dir = 0; target = 4'd6; step(); start = 0;
    step();
    advance_to(4'd2, "pause");
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      start = (i == 1); target = 4'd0; dir = 1;
      #1;
      checks++; if (t_en !== 4'd0) begin errors++; $display("FAIL pause_t_en i=%0d got %0h exp 0", i, t_en); end
      checks++; if (bank !== 4'd2) begin errors++; $display("FAIL pause_hold i=%0d got %0h exp 2", i, bank); end
      step();
    end
    start = 0; pause = 0;
    dcnt = 0; qdone = 4'hx;
    for (int i = 0; i < 15; i++) begin
      if (done) begin dcnt++; qdone = bank; end
      step();
    end
    checks++; if (dcnt != 1) begin errors++; $display("FAIL pause_done_count got %0d exp 1", dcnt); end
    checks++; if (qdone !== 4'd6) begin errors++; $display("FAIL pause_done_q got %0h exp 6", qdone); end
  endtask

  task automatic test_reset_mid();
    int dcnt;
    start = 1; dir = 0; target = 4'd12; step(); start = 0;
    step();
    advance_to(4'd6, "rstmid");
    reset = 0; #1;
    checks++; if ({t_en, tff_clr, busy, done} !== 7'd0) begin errors++; $display("FAIL rstmid_async got %0h exp 0", {t_en, tff_clr, busy, done}); end
    step(); step();
    reset = 1;
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) dcnt++;
      step();
    end
    checks++; if (dcnt != 0) begin errors++; $display("FAIL rstmid_idle got %0d exp 0", dcnt); end
    checks++; if (bank !== 4'd6) begin errors++; $display("FAIL rstmid_frozen got %0h exp 6", bank); end
    do_run(1'b0, 4'd2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      do_run(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_count_up();
    test_count_down();
    test_target_zero();
    test_abort();
    test_pause();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

endmodule
